// File: rtl/lcd_seq_ctrl.sv
// HD44780 character-LCD sequencer: runs the power-up init sequence after reset, then writes one
// byte per valid/ready handshake with the RS/EN/DATA setup, pulse, hold and busy-wait timing.
module lcd_seq_ctrl #(
   parameter int unsigned T_POWERUP = 750000,
   parameter int unsigned T_SETUP   = 2,
   parameter int unsigned T_EN      = 12,
   parameter int unsigned T_HOLD    = 2,
   parameter int unsigned T_CMD     = 2000,
   parameter int unsigned T_LONG    = 82000,
   parameter int unsigned CNT_W     = 20
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   input  logic        req_rs_i,
   input  logic [7:0]  req_data_i,
   output logic        req_ready_o,
   output logic        init_done_o,
   output logic        busy_o,
   output logic [31:0] lcd_o
);

   typedef enum logic [2:0] {StPwrup, StSetup, StPulse, StHold, StWait, StIdle} state_e;

   localparam logic [CNT_W-1:0] LdPwrup = CNT_W'(T_POWERUP - 1);
   localparam logic [CNT_W-1:0] LdSetup = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] LdEn    = CNT_W'(T_EN - 1);
   localparam logic [CNT_W-1:0] LdHold  = CNT_W'(T_HOLD - 1);
   localparam logic [CNT_W-1:0] LdCmd   = CNT_W'(T_CMD - 1);
   localparam logic [CNT_W-1:0] LdLong  = CNT_W'(T_LONG - 1);

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      case (idx)
         2'd0:    init_cmd = 8'h38;
         2'd1:    init_cmd = 8'h0C;
         2'd2:    init_cmd = 8'h01;
         default: init_cmd = 8'h06;
      endcase
   endfunction

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       idx_q;
   logic             init_done_q, on_q, en_q, rs_q, ready_q, busy_q;
   logic [7:0]       data_q;
   logic             cnt_zero, long_wait;

   assign cnt_zero  = (cnt_q == '0);
   // Clear (0x01) and return-home (0x02/0x03) need the long busy wait.
   assign long_wait = !rs_q && (data_q inside {8'h01, 8'h02, 8'h03});

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StPwrup;
         cnt_q       <= LdPwrup;
         idx_q       <= 2'd0;
         init_done_q <= 1'b0;
         on_q        <= 1'b0;
         en_q        <= 1'b0;
         rs_q        <= 1'b0;
         data_q      <= 8'h00;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         on_q    <= 1'b1;
         en_q    <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b1;
         if (!cnt_zero) cnt_q <= cnt_q - 1'b1;
         unique case (state_q)
            StPwrup: begin
               if (cnt_zero) begin
                  state_q <= StSetup;
                  cnt_q   <= LdSetup;
                  rs_q    <= 1'b0;
                  data_q  <= init_cmd(2'd0);
               end
            end
            StSetup: begin
               en_q <= cnt_zero;
               if (cnt_zero) begin
                  state_q <= StPulse;
                  cnt_q   <= LdEn;
               end
            end
            StPulse: begin
               en_q <= !cnt_zero;
               if (cnt_zero) begin
                  state_q <= StHold;
                  cnt_q   <= LdHold;
               end
            end
            StHold: begin
               if (cnt_zero) begin
                  state_q <= StWait;
                  cnt_q   <= long_wait ? LdLong : LdCmd;
               end
            end
            StWait: begin
               if (cnt_zero) begin
                  if (!init_done_q && idx_q != 2'd3) begin
                     idx_q   <= idx_q + 2'd1;
                     state_q <= StSetup;
                     cnt_q   <= LdSetup;
                     data_q  <= init_cmd(idx_q + 2'd1);
                  end else begin
                     init_done_q <= 1'b1;
                     state_q     <= StIdle;
                     ready_q     <= 1'b1;
                     busy_q      <= 1'b0;
                  end
               end
            end
            StIdle: begin
               if (req_valid_i && ready_q) begin
                  state_q <= StSetup;
                  cnt_q   <= LdSetup;
                  rs_q    <= req_rs_i;
                  data_q  <= req_data_i;
               end else begin
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StPwrup;
               cnt_q   <= LdPwrup;
            end
         endcase
      end
   end

   assign req_ready_o = ready_q;
   assign init_done_o = init_done_q;
   assign busy_o      = busy_q;
   assign lcd_o       = {on_q, 20'b0, en_q, rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Bench for lcd_seq_ctrl: init sequence, directed and random byte transfers checked against
// timing windows derived from the T_* parameters, ignored requests and mid-pulse reset.
module tb_lcd_seq_ctrl;

   localparam int TP = 10, TS = 2, TE = 3, TH = 1, TC = 5, TL = 20;
   localparam int XFER   = TS + TE + TH;
   localparam int T_INIT = TP + 4 * XFER + 3 * TC + TL;
   localparam int N      = 24;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_rs = 1'b0;
   logic [7:0]  req_data = 8'h00;
   logic        req_ready, init_done, busy;
   logic [31:0] lcd;

   int n_checks = 0;
   int n_fail   = 0;

   lcd_seq_ctrl #(
      .T_POWERUP(TP), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_CMD(TC), .T_LONG(TL), .CNT_W(8)
   ) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .req_valid_i(req_valid),
      .req_rs_i   (req_rs),
      .req_data_i (req_data),
      .req_ready_o(req_ready),
      .init_done_o(init_done),
      .busy_o     (busy),
      .lcd_o      (lcd)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int wait_len(input logic rs, input logic [7:0] data);
      return (!rs && data >= 8'h01 && data <= 8'h03) ? TL : TC;
   endfunction

   // Holds reset, releases it and follows the whole init sequence; valid is asserted junk
   // throughout power-up to show it is ignored.
   task automatic reset_init();
      logic [7:0] exp_cmd [4];
      logic [7:0] seen [$];
      int k = 0, width = 0;
      logic prev_en = 1'b0;
      logic width_ok = 1'b1, rs_ok = 1'b1, busy_ok = 1'b1, on_ok = 1'b1;
      exp_cmd = '{8'h38, 8'h0C, 8'h01, 8'h06};
      rst_n = 1'b0;
      req_valid = 1'b1;
      req_rs = 1'b1;
      req_data = 8'hA5;
      repeat (3) @(negedge clk);
      check_eq("rst_lcd", lcd, 32'h0);
      check_eq("rst_flags", {busy, req_ready, init_done}, 3'b000);
      rst_n = 1'b1;
      while (!init_done && k < 500) begin
         @(negedge clk);
         k++;
         if (k == TP) req_valid = 1'b0;
         if (k == 1) check_eq("on_first_edge", lcd[31], 1'b1);
         if (!lcd[31]) on_ok = 1'b0;
         if (!init_done && !busy) busy_ok = 1'b0;
         if (lcd[10]) begin
            if (!prev_en) seen.push_back(lcd[7:0]);
            if (lcd[9]) rs_ok = 1'b0;
            width++;
         end else if (prev_en) begin
            if (width != TE) width_ok = 1'b0;
            width = 0;
         end
         prev_en = lcd[10];
      end
      check_eq("init_cycles", k, T_INIT);
      check_eq("init_ready_busy", {req_ready, busy}, 2'b10);
      check_eq("init_pulse_count", seen.size(), 4);
      for (int i = 0; i < 4 && i < seen.size(); i++) check_eq("init_cmd", seen[i], exp_cmd[i]);
      check_eq("init_en_width", width_ok, 1'b1);
      check_eq("init_rs_zero", rs_ok, 1'b1);
      check_eq("init_busy_high", busy_ok, 1'b1);
      check_eq("init_on_stays", on_ok, 1'b1);
   endtask

   // Called at the first negedge-phase point after the accept edge; follows one transfer until
   // ready returns. With junk set, a stray request is raised during the busy wait.
   task automatic observe(input logic rs, input logic [7:0] data, input logic junk);
      int exp_low = XFER + wait_len(rs, data);
      int low = 0, n_en = 0, en_start = -1, rises = 0;
      logic prev_en = 1'b0, fields_ok = 1'b1, misc_ok = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (req_ready) break;
         low++;
         if (lcd[10]) begin
            if (en_start < 0) en_start = k;
            if (!prev_en) rises++;
            n_en++;
         end
         prev_en = lcd[10];
         if (k < XFER && (lcd[9] !== rs || lcd[7:0] !== data)) fields_ok = 1'b0;
         if (!busy || !lcd[31] || lcd[8]) misc_ok = 1'b0;
         if (junk && k == XFER) begin
            req_valid = 1'b1;
            req_rs = 1'($urandom);
            req_data = 8'($urandom);
         end
         if (junk && k == exp_low - 1) req_valid = 1'b0;
      end
      check_eq("ready_low_len", low, exp_low);
      check_eq("en_start", en_start, TS);
      check_eq("en_width", n_en, TE);
      check_eq("en_single_pulse", rises, 1);
      check_eq("xfer_fields", fields_ok, 1'b1);
      check_eq("xfer_busy_on_rw", misc_ok, 1'b1);
      check_eq("idle_retain", {lcd[10], lcd[9], lcd[7:0]}, {1'b0, rs, data});
      check_eq("idle_busy", busy, 1'b0);
   endtask

   logic       t_rs   [N];
   logic [7:0] t_data [N];
   logic       t_b2b  [N];

   initial begin
      logic chained = 1'b0;
      logic junk;
      int waits;

      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic chained;
      logic junk;
      int waits, gap;

      // Directed prefix, then random bytes biased towards the long-wait instructions.
      t_rs[0] = 1'b1; t_data[0] = 8'h41; t_b2b[0] = 1'b0;
      t_rs[1] = 1'b0; t_data[1] = 8'h01; t_b2b[1] = 1'b0;
      t_rs[2] = 1'b1; t_data[2] = 8'h01; t_b2b[2] = 1'b0;
      t_rs[3] = 1'b1; t_data[3] = 8'h48; t_b2b[3] = 1'b1;
      t_rs[4] = 1'b1; t_data[4] = 8'h49; t_b2b[4] = 1'b1;
      t_rs[5] = 1'b1; t_data[5] = 8'h21; t_b2b[5] = 1'b0;
      for (int i = 6; i < N; i++) begin
         t_rs[i]   = 1'($urandom);
         t_data[i] = ($urandom % 4 == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
         t_b2b[i]  = ($urandom % 3 == 0);
      end

      reset_init();

      chained = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!chained) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
               @(negedge clk);
               check_eq("idle_gap", {req_ready, lcd[10]}, 2'b10);
            end
            req_valid = 1'b1;
            req_rs = t_rs[i];
            req_data = t_data[i];
         end
         waits = 0;
         while (!req_ready && waits < 200) begin
            @(negedge clk);
            waits++;
         end
         if (chained) check_eq("b2b_no_bubble", waits, 0);
         else check_eq("accept_wait", waits < 200, 1'b1);
         @(posedge clk);
         #1;
         chained = (i < N - 1) && t_b2b[i];
         if (chained) begin
            req_rs = t_rs[i+1];
            req_data = t_data[i+1];
         end else begin
            req_valid = 1'b0;
            req_rs = 1'($urandom);
            req_data = 8'($urandom);
         end
         junk = !chained && ($urandom % 2 == 1);
         observe(t_rs[i], t_data[i], junk);
      end

      // Reset in the middle of an EN pulse must clear the LCD word without a clock edge.
      @(negedge clk);
      req_valid = 1'b1;
      req_rs = 1'b1;
      req_data = 8'h55;
      waits = 0;
      while (!req_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      waits = 0;
      while (!lcd[10] && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      check_eq("mid_pulse_en_seen", lcd[10], 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_lcd", lcd, 32'h0);
      check_eq("async_rst_flags", {busy, req_ready, init_done}, 3'b000);
      reset_init();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_seq_ctrl.md
Name: lcd_seq_ctrl

Overview:
- Hardware sequencer for the board's HD44780-compatible character LCD. It replaces software bit-banging of the LCD I/O register.
- After reset it runs the power-up init sequence on its own.
- It then accepts one byte per valid/ready handshake and produces the RS/RW/EN/DATA timing and busy waits.
- Output is packed in the same 32-bit LCD word layout the top level already unpacks: bit31 ON, bit10 EN, bit9 RS, bit8 RW, bits7:0 DATA.

Parameters:
- T_POWERUP, 750000, cycles to wait after reset before the first init command (15 ms at 50 MHz)
- T_SETUP, 2, cycles RS/DATA are stable before EN rises
- T_EN, 12, cycles EN is held high
- T_HOLD, 2, cycles RS/DATA are held after EN falls
- T_CMD, 2000, busy wait after a normal command or data write (40 us)
- T_LONG, 82000, busy wait after clear/home (1.64 ms)
- CNT_W, 20, width of the shared timing counter; must satisfy 2^CNT_W > every T_* value

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset
- req_valid_i  in  1  requester has a byte
- req_rs_i  in  1  0 = instruction, 1 = data
- req_data_i  in  8  byte to write
- req_ready_o  out  1  byte accepted on the cycle where valid and ready are both high
- init_done_o  out  1  init sequence complete; stays high until reset
- busy_o  out  1  a transfer or wait is in progress, including init
- lcd_o  out  32  packed LCD word; unused bits are 0

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_ni low, asynchronous): all outputs 0, so lcd_o = 0 (ON = 0, EN = 0). State = PWRUP, init index = 0.
- All outputs are registered.
- ON is 1 from the first clock edge after reset release onward. RW is always 0.
- Timed states: each lasts exactly its T_* cycles (T >= 1). The counter loads T-1 on entry, and the state exits on the edge where the counter equals 0.
- PWRUP: lasts T_POWERUP cycles, then goes to SETUP with init command 0.
- Init commands, issued in order with RS = 0:
  - 0x38 (function set, 8-bit, 2-line)
  - 0x0C (display on)
  - 0x01 (clear)
  - 0x06 (entry mode)
- SETUP: drive RS/DATA with EN = 0 for T_SETUP cycles, then go to PULSE.
- PULSE: EN = 1 for T_EN cycles, then go to HOLD.
- HOLD: EN = 0, RS/DATA unchanged, for T_HOLD cycles, then go to WAIT.
- WAIT: lasts T_LONG if RS = 0 and DATA is 0x01, 0x02 or 0x03; otherwise T_CMD.
- End of WAIT:
  - During init with index < 3: increment the index and go to SETUP.
  - During init with index = 3: set init_done_o and go to IDLE.
  - Otherwise: go to IDLE.
- IDLE: req_ready_o = 1, busy_o = 0.
  - On valid && ready, capture rs/data and go to SETUP next cycle. req_ready_o drops on that same edge.
- Ready-low window per accepted byte: exactly T_SETUP + T_EN + T_HOLD + T_WAIT cycles, then ready returns high.
- Requester rules: the requester holds rs/data stable while valid && !ready. Requests in any state other than IDLE are ignored, with no queuing.
- RS/DATA retain the last written values while in IDLE.
- busy_o = !(state == IDLE). It is 0 during reset and 1 from the first edge after reset release.
- No handshake is possible before init_done_o = 1.
- Reset mid-operation: EN drops to 0 asynchronously. On release the full init sequence reruns, including PWRUP.
- Back-to-back: valid held high across IDLE causes the next byte to be accepted on the first IDLE cycle. There are no bubbles beyond one IDLE cycle.

Test Plan:
- Bench parameters: T_POWERUP=10, T_SETUP=2, T_EN=3, T_HOLD=1, T_CMD=5, T_LONG=20.
- Release reset, no requests -> lcd_o=0 during reset; ON=1 from the first edge after release. EN pulses 4 times, each 3 cycles wide, with DATA 0x38, 0x0C, 0x01, 0x06 and RS=0. init_done_o and req_ready_o rise 69 cycles after release (10 + 4×6 + 5+5+20+5). busy_o is 1 throughout that window.
- After init, send RS=1, 0x41 -> lcd_o[9]=1, lcd_o[7:0]=0x41 for SETUP+PULSE+HOLD. EN high exactly 3 cycles, starting 2 cycles after the accept edge. ready is low for exactly 11 cycles.
- Send RS=0, 0x01, then RS=1, 0x01 -> the first transfer's ready-low window is 26 cycles (long wait); the second is 11 cycles (data 0x01 is not a clear).
- Hold valid high for three bytes 0x48, 0x49, 0x21 while changing data only on accept -> exactly three EN pulses with the correct bytes. Each accept occurs on the first IDLE cycle; no byte is duplicated or lost.
- Assert req_valid_i during PWRUP and during WAIT -> no handshake, no EN pulse outside the schedule.
- Pull rst_ni low mid-PULSE (EN=1) -> lcd_o=0 immediately, without waiting for a clock edge. After release, init_done_o is 0 and the init sequence restarts from PWRUP, completing after 69 cycles.
